sw_conditioner: RTL and testbench

SW_CONDITIONER -- requirements
Module: sw_conditioner

---
 rtl/sw_conditioner.sv | 99 +++++++++
 tb/tb_sw_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_conditioner.sv
// Three-channel switch conditioner: each raw switch is synchronized, then
// debounced by a per-channel counter. The debounced levels A/C/D come straight
// from flops so the downstream combinational stage never sees glitches. A
// registered change pulse with a per-channel mask accompanies every update.
module sw_conditioner #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_a,
    input  logic       sw_c,
    input  logic       sw_d,
    output logic       A,
    output logic       C,
    output logic       D,
    output logic       chg,
    output logic [2:0] chg_mask,
    output logic       busy
);

    // Last count value before the output is allowed to follow the input.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

    // Channel order everywhere: bit2 = A, bit1 = C, bit0 = D.
    logic [2:0]            raw;
    logic [2:0]            s1_q;
    logic [2:0]            s2_q;
    logic [2:0]            out_q;
    logic [2:0]            out_d;
    logic [2:0][CNT_W-1:0] cnt_q;
    logic [2:0][CNT_W-1:0] cnt_d;
    logic [2:0]            mask_d;
    logic [2:0]            chg_mask_q;
    logic                  chg_q;

    assign raw = {sw_a, sw_c, sw_d};

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 3'b000;
            s2_q <= 3'b000;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce state: counter (0 = stable), output level and change flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            out_q      <= 3'b000;
            chg_mask_q <= 3'b000;
            chg_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            chg_mask_q <= mask_d;
            chg_q      <= |mask_d;
        end
    end

    // Next-state: any agreement resets the count; DEB_CYCLES straight disagreements commit.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        mask_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                out_d[i]  = s2_q[i];
                cnt_d[i]  = '0;
                mask_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Busy whenever any channel is mid-count.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (cnt_q[i] != '0) begin
                busy = 1'b1;
            end
        end
    end

    assign A        = out_q[2];
    assign C        = out_q[1];
    assign D        = out_q[0];
    assign chg      = chg_q;
    assign chg_mask = chg_mask_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner with DEB_CYCLES = 4: a reference model that flips a
// channel once its synchronized sample has disagreed with the held level for
// DEB consecutive edges, a per-cycle compare, and directed literal checks.
module tb_sw_conditioner;

    localparam int Deb = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       sw_a  = 1'b0;
    logic       sw_c  = 1'b0;
    logic       sw_d  = 1'b0;
    logic       A;
    logic       C;
    logic       D;
    logic       chg;
    logic [2:0] chg_mask;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    sw_conditioner #(
        .DEB_CYCLES (Deb),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_a     (sw_a),
        .sw_c     (sw_c),
        .sw_d     (sw_d),
        .A        (A),
        .C        (C),
        .D        (D),
        .chg      (chg),
        .chg_mask (chg_mask),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance n clocks; returns just after the falling edge, well away from posedge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference model (bit2 = A, bit1 = C, bit0 = D).
    logic [2:0] m_s1;
    logic [2:0] m_s2;
    logic [2:0] m_out;
    logic [2:0] m_mask;
    logic       m_chg;
    int         m_run [3];

    always @(posedge clk or negedge rst_n) begin : model
        logic [2:0] flip;
        flip = 3'b000;
        if (!rst_n) begin
            m_s1   <= 3'b000;
            m_s2   <= 3'b000;
            m_out  <= 3'b000;
            m_mask <= 3'b000;
            m_chg  <= 1'b0;
            for (int i = 0; i < 3; i++) m_run[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_out[i]) begin
                    if (m_run[i] + 1 >= Deb) begin
                        flip[i] = 1'b1;
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_out  <= m_out ^ flip;
            m_mask <= flip;
            m_chg  <= |flip;
            m_s2   <= m_s1;
            m_s1   <= {sw_a, sw_c, sw_d};
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_run[0] != 0) || (m_run[1] != 0) || (m_run[2] != 0);
        chk("model_cmp {A,C,D,chg,mask,busy}",
            32'({A, C, D, chg, chg_mask, busy}),
            32'({m_out, m_chg, m_mask, m_busy}));
    end

    logic seen_chg;
    logic seen_busy;

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", 32'({A, C, D, chg, chg_mask, busy}), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Single channel rise: A at k+5, busy k+2..k+4, one chg with 100.
        sw_a = 1'b1;
        tick(2);
        chk("a_busy_k1", 32'(busy), 32'd0);
        tick(1);
        chk("a_busy_k2", 32'(busy), 32'd1);
        tick(2);
        chk("a_busy_k4", 32'(busy), 32'd1);
        chk("a_still_low_k4", 32'(A), 32'd0);
        tick(1);
        chk("a_rise_k5", 32'({A, chg, chg_mask, busy}), 32'b1_1_100_0);
        tick(1);
        chk("a_chg_one_cycle", 32'({A, chg, chg_mask}), 32'b1_0_000);
        sw_a = 1'b0;
        tick(8);

        // Short pulse on C is rejected.
        seen_chg  = 1'b0;
        seen_busy = 1'b0;
        sw_c = 1'b1;
        tick(2);
        sw_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (chg || C) seen_chg = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        chk("c_glitch_no_chg", 32'(seen_chg), 32'd0);
        chk("c_glitch_busy_seen", 32'(seen_busy), 32'd1);
        chk("c_glitch_idle", 32'({C, busy}), 32'd0);

        // All three rise together.
        sw_a = 1'b1;
        sw_c = 1'b1;
        sw_d = 1'b1;
        tick(5);
        chk("all_low_k4", 32'({A, C, D, chg}), 32'd0);
        tick(1);
        chk("all_rise_k5", 32'({A, C, D, chg, chg_mask}), 32'b111_1_111);
        tick(1);
        chk("all_chg_clear", 32'({chg, chg_mask}), 32'd0);

        // D falls with one bounce: 0,1,0,0,...
        sw_d = 1'b0;
        tick(1);
        sw_d = 1'b1;
        tick(1);
        sw_d = 1'b0;
        tick(5);
        chk("d_bounce_held_k6", 32'({D, chg}), 32'b1_0);
        tick(1);
        chk("d_fall_k7", 32'({D, chg, chg_mask}), 32'b0_1_001);
        sw_a = 1'b0;
        sw_c = 1'b0;
        tick(8);

        // Reset in the middle of a count.
        sw_a = 1'b1;
        tick(4);
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cleared", 32'({A, chg, chg_mask, busy}), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("rst_mid_a_low_j4", 32'(A), 32'd0);
        tick(1);
        chk("rst_mid_a_rise_j5", 32'({A, chg, chg_mask}), 32'b1_1_100);
        sw_a = 1'b0;
        tick(8);

        // Staggered A then C: consecutive chg pulses with separate masks.
        sw_a = 1'b1;
        tick(1);
        sw_c = 1'b1;
        tick(5);
        chk("stagger_a_k5", 32'({A, C, chg, chg_mask}), 32'b1_0_1_100);
        tick(1);
        chk("stagger_c_k6", 32'({A, C, chg, chg_mask}), 32'b1_1_1_010);
        tick(1);
        chk("stagger_clear", 32'({chg, chg_mask}), 32'd0);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
